// File: rtl/bus_pkg.sv
// Shared types for the round-robin bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after start, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  winner_oh,
    output logic [IW-1:0] winner_idx,
    output logic          found
);

    int j;

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        found      = 1'b0;
        j          = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(start) + i) % N;
            if (!found && req[j]) begin
                found      = 1'b1;
                winner_idx = IW'(j);
                winner_oh  = N'(1) << j;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with idle-grant timeout and single outstanding split transaction.
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS   = 4,
    parameter int SPLIT_EN      = 1,
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         breq,
    input  logic                           bus_active,
    input  logic                           slave_split,
    input  logic                           split_release,
    output logic [NUM_MASTERS-1:0]         bgrant,
    output logic [NUM_MASTERS-1:0]         split,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    output logic                           grant_valid,
    output arb_state_t                     state_dbg
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int TW = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;
    localparam logic [TW:0] TLIM = (TW + 1)'(GRANT_TIMEOUT);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] bgrant_q, bgrant_d;
    logic [NUM_MASTERS-1:0] split_q, split_d;
    logic [IW-1:0]          grant_id_q, grant_id_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic                   prio_q, prio_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;

    logic                   split_pend, rel_now, take_split, prio_hit;
    logic [NUM_MASTERS-1:0] eligible, pick_oh;
    logic [IW-1:0]          pick_idx;
    logic                   pick_found;
    logic [TW:0]            tinc;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
        next_ptr = (int'(i) == NUM_MASTERS - 1) ? '0 : i + 1'b1;
    endfunction

    assign split_pend = |split_q;
    assign rel_now    = (SPLIT_EN != 0) && split_release && split_pend;
    assign take_split = (SPLIT_EN != 0) && slave_split && !split_pend;
    // A release arriving this cycle unparks the owner and lets it claim priority immediately.
    assign eligible   = breq & ~(rel_now ? '0 : split_q);
    assign prio_hit   = (prio_q || rel_now) && breq[owner_q];
    assign tinc       = {1'b0, tcnt_q} + (TW + 1)'(1);

    rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req        (eligible),
        .start      (ptr_q),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .found      (pick_found)
    );

    always_comb begin
        state_d    = state_q;
        bgrant_d   = bgrant_q;
        split_d    = split_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        tcnt_d     = tcnt_q;

        if (rel_now) begin
            split_d = '0;
            prio_d  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (prio_hit) begin
                    bgrant_d   = NUM_MASTERS'(1) << owner_q;
                    grant_id_d = owner_q;
                    ptr_d      = next_ptr(owner_q);
                    prio_d     = 1'b0;
                    tcnt_d     = '0;
                    state_d    = GRANT;
                end else if (pick_found) begin
                    bgrant_d   = pick_oh;
                    grant_id_d = pick_idx;
                    ptr_d      = next_ptr(pick_idx);
                    tcnt_d     = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // Split wins over a simultaneous request drop.
                if (take_split) begin
                    split_d  = bgrant_q;
                    owner_d  = grant_id_q;
                    bgrant_d = '0;
                    state_d  = RELEASE;
                end else if (!breq[grant_id_q]) begin
                    bgrant_d = '0;
                    state_d  = RELEASE;
                end else if (bus_active) begin
                    tcnt_d = '0;
                end else if (GRANT_TIMEOUT != 0 && tinc == TLIM) begin
                    bgrant_d = '0;
                    state_d  = RELEASE;
                end else begin
                    tcnt_d = tinc[TW-1:0];
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                bgrant_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bgrant_q   <= '0;
            split_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            owner_q    <= '0;
            prio_q     <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            bgrant_q   <= bgrant_d;
            split_q    <= split_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign bgrant      = bgrant_q;
    assign split       = (SPLIT_EN != 0) ? split_q : '0;
    assign grant_id    = grant_id_q;
    assign grant_valid = |bgrant_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: per-cycle vector table plus round-robin and timeout sequences.
module tb_bus_arbiter_rr;
    import bus_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] breq = '0;
    logic       bus_active = 1'b0;
    logic       slave_split = 1'b0;
    logic       split_release = 1'b0;
    logic [3:0] bgrant;
    logic [3:0] split;
    logic [1:0] grant_id;
    logic       grant_valid;
    arb_state_t state_dbg;

    int errors = 0;
    int checks = 0;
    logic [10:0] exp_q[$];

    typedef struct {
        logic       r;
        logic [3:0] b;
        logic       ba, ss, sr;
        logic [3:0] bg, sp;
        logic [1:0] gid;
        string      nm;
    } vec_t;
    vec_t vecs[$];

    bus_arbiter_rr #(
        .NUM_MASTERS   (4),
        .SPLIT_EN      (1),
        .GRANT_TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .breq          (breq),
        .bus_active    (bus_active),
        .slave_split   (slave_split),
        .split_release (split_release),
        .bgrant        (bgrant),
        .split         (split),
        .grant_id      (grant_id),
        .grant_valid   (grant_valid),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] b, input logic ba, input logic ss,
                       input logic sr, input logic [3:0] bg, input logic [3:0] sp,
                       input logic [1:0] gid, input string nm);
        vec_t v;
        v.r = r; v.b = b; v.ba = ba; v.ss = ss; v.sr = sr;
        v.bg = bg; v.sp = sp; v.gid = gid; v.nm = nm;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm);
        logic [10:0] e;
        logic [10:0] a;
        checks++;
        a = {bgrant, split, grant_valid, grant_id};
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got bgrant=%b split=%b", nm, bgrant, split);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got bgrant=%b split=%b valid=%b id=%0d, want bgrant=%b split=%b valid=%b id=%0d",
                         nm, a[10:7], a[6:3], a[2], a[1:0], e[10:7], e[6:3], e[2], e[1:0]);
            end
        end
    endtask

    // driver: apply one cycle of inputs, expect the outputs after the following edge
    task automatic cyc(input logic r, input logic [3:0] b, input logic ba, input logic ss,
                       input logic sr, input logic [3:0] bg, input logic [3:0] sp,
                       input logic [1:0] gid, input string nm);
        @(negedge clk);
        rst = r; breq = b; bus_active = ba; slave_split = ss; split_release = sr;
        exp_q.push_back({bg, sp, |bg, gid});
        @(posedge clk);
        #1;
        check(nm);
    endtask

    initial begin
        logic [3:0] oh;
        logic [1:0] m;

        // basic grant, latency, round-robin from pointer
        add(1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "reset");
        add(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "idle_no_req");
        add(0, 4'b0100, 0, 0, 0, 4'b0100, 4'b0000, 2'd2, "grant_latency_m2");
        add(0, 4'b0100, 1, 0, 0, 4'b0100, 4'b0000, 2'd2, "grant_hold_m2");
        add(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd2, "release_m2");
        add(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd2, "gid_holds");
        add(0, 4'b1001, 0, 0, 0, 4'b1000, 4'b0000, 2'd3, "rr_from_ptr3");
        add(0, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 2'd3, "release_m3");
        add(0, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 2'd3, "idle_after_m3");
        add(0, 4'b0001, 0, 0, 0, 4'b0001, 4'b0000, 2'd0, "rr_wrap_m0");
        add(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "release_m0");
        add(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "idle_m0");
        // split of master 1, master 0 served, release mid-grant
        add(1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "c_reset");
        add(0, 4'b0010, 0, 0, 0, 4'b0010, 4'b0000, 2'd1, "c_grant_m1");
        add(0, 4'b0010, 1, 1, 0, 4'b0000, 4'b0010, 2'd1, "c_split_m1");
        add(0, 4'b0011, 0, 0, 0, 4'b0000, 4'b0010, 2'd1, "c_release");
        add(0, 4'b0011, 0, 0, 0, 4'b0001, 4'b0010, 2'd0, "c_m1_parked");
        add(0, 4'b0011, 1, 0, 1, 4'b0001, 4'b0000, 2'd0, "c_no_preempt");
        add(0, 4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "c_release_m0");
        add(0, 4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "c_idle");
        add(0, 4'b0011, 0, 0, 0, 4'b0010, 4'b0000, 2'd1, "c_owner_next");
        add(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd1, "c_release_m1");
        add(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd1, "c_idle_end");
        // second split ignored; released owner beats pointer
        add(1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "d_reset");
        add(0, 4'b0001, 0, 0, 0, 4'b0001, 4'b0000, 2'd0, "d_grant_m0");
        add(0, 4'b0001, 0, 1, 0, 4'b0000, 4'b0001, 2'd0, "d_split_m0");
        add(0, 4'b0111, 0, 0, 0, 4'b0000, 4'b0001, 2'd0, "d_release");
        add(0, 4'b0111, 0, 0, 0, 4'b0010, 4'b0001, 2'd1, "d_grant_m1");
        add(0, 4'b0111, 1, 1, 0, 4'b0010, 4'b0001, 2'd1, "d_second_split");
        add(0, 4'b0111, 0, 0, 1, 4'b0010, 4'b0000, 2'd1, "d_split_rel");
        add(0, 4'b0101, 0, 0, 0, 4'b0000, 4'b0000, 2'd1, "d_release_m1");
        add(0, 4'b0101, 0, 0, 0, 4'b0000, 4'b0000, 2'd1, "d_idle");
        add(0, 4'b0101, 0, 0, 0, 4'b0001, 4'b0000, 2'd0, "d_prio_over_ptr");
        add(0, 4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "d_release_m0");
        add(0, 4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "d_idle2");
        add(0, 4'b0100, 0, 0, 0, 4'b0100, 4'b0000, 2'd2, "d_prio_cleared");
        add(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd2, "d_release_m2");
        add(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd2, "d_idle_end");
        // ignored pulses, drop+split, release at RELEASE->IDLE, reset mid-split
        add(1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "e_reset");
        add(0, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 2'd0, "e_split_in_idle");
        add(0, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000, 2'd0, "e_rel_no_split");
        add(0, 4'b0100, 0, 0, 0, 4'b0100, 4'b0000, 2'd2, "e_grant_m2");
        add(0, 4'b0000, 0, 1, 0, 4'b0000, 4'b0100, 2'd2, "e_drop_and_split");
        add(0, 4'b0001, 0, 0, 1, 4'b0000, 4'b0000, 2'd2, "e_rel_at_idle");
        add(0, 4'b0101, 0, 0, 0, 4'b0100, 4'b0000, 2'd2, "e_owner_first");
        add(0, 4'b0101, 1, 0, 0, 4'b0100, 4'b0000, 2'd2, "e_hold_m2");
        add(0, 4'b0101, 0, 1, 0, 4'b0000, 4'b0100, 2'd2, "e_split_m2");
        add(0, 4'b0001, 0, 0, 0, 4'b0000, 4'b0100, 2'd2, "e_release");
        add(0, 4'b0001, 0, 0, 0, 4'b0001, 4'b0100, 2'd0, "e_grant_m0_split");
        add(1, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "e_reset_mid");
        add(0, 4'b1111, 0, 0, 0, 4'b0001, 4'b0000, 2'd0, "e_ptr_zero");
        add(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "e_release_end");
        add(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "e_idle_end");

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].r, vecs[i].b, vecs[i].ba, vecs[i].ss, vecs[i].sr,
                vecs[i].bg, vecs[i].sp, vecs[i].gid, vecs[i].nm);
        end

        // all masters requesting: order 0,1,2,3,0
        cyc(1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "rr_reset");
        for (int k = 0; k < 5; k++) begin
            m  = 2'(k % 4);
            oh = 4'b0001 << m;
            for (int t = 0; t < 3; t++)
                cyc(0, 4'b1111, 1, 0, 0, oh, 4'b0000, m, "rr_order_grant");
            cyc(0, 4'b1111 & ~oh, 1, 0, 0, 4'b0000, 4'b0000, m, "rr_order_release");
            cyc(0, 4'b1111, 1, 0, 0, 4'b0000, 4'b0000, m, "rr_order_idle");
        end

        // idle-grant timeout, then restart of the count by a bus_active pulse
        cyc(1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "to_reset");
        cyc(0, 4'b1000, 0, 0, 0, 4'b1000, 4'b0000, 2'd3, "to_grant_m3");
        for (int t = 1; t < 16; t++)
            cyc(0, 4'b1000, 0, 0, 0, 4'b1000, 4'b0000, 2'd3, "to_hold");
        cyc(0, 4'b1000, 0, 0, 0, 4'b0000, 4'b0000, 2'd3, "to_revoke_16");
        cyc(0, 4'b1000, 0, 0, 0, 4'b0000, 4'b0000, 2'd3, "to_release");
        cyc(0, 4'b1000, 0, 0, 0, 4'b1000, 4'b0000, 2'd3, "to_still_eligible");
        for (int t = 1; t < 10; t++)
            cyc(0, 4'b1000, 0, 0, 0, 4'b1000, 4'b0000, 2'd3, "to_pre_pulse");
        cyc(0, 4'b1000, 1, 0, 0, 4'b1000, 4'b0000, 2'd3, "to_pulse");
        for (int t = 1; t < 16; t++)
            cyc(0, 4'b1000, 0, 0, 0, 4'b1000, 4'b0000, 2'd3, "to_restarted");
        cyc(0, 4'b1000, 0, 0, 0, 4'b0000, 4'b0000, 2'd3, "to_revoke_after_pulse");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
